frame_tx_arbiter: RTL and testbench
===================================

Name: frame_tx_arbiter

Overview:
- Schedules the single packet_sender input stream between two sources: the dscope frame stream (large, sync-driven) and a short status/reply stream.
- Latches a packet request from each source and grants whole packets, never interleaving words.
- Drives a per-packet start pulse with a UDP byte length.
- Counts beats so each packet is exactly its announced length.

Parameters:
- IFG_CYCLES, 4, idle cycles forced between packets (0 allowed = back-to-back).
- TIMEOUT_CYC, 1024, stall watchdog limit in cycles (used only with TX_TIMEOUT_EN).
- STAT_PRIO, 0, 1 = status always wins a tie; 0 = round-robin.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_frm_ready  in  1  one-cycle pulse: a scope frame is available.
- i_frm_size  in  16  frame length in 32-bit words; sampled with i_frm_ready; bits [15:14] ignored.
- i_frm_data  in  32  frame stream data.
- i_frm_vld  in  1  frame stream valid.
- o_frm_rdy  out  1  frame stream ready.
- i_stat_req  in  1  one-cycle pulse: a status packet is available.
- i_stat_len  in  8  status length in words; sampled with i_stat_req.
- i_stat_data  in  32  status stream data.
- i_stat_vld  in  1  status stream valid.
- o_stat_rdy  out  1  status stream ready.
- o_out_data  out  32  to packet_sender.
- o_out_vld  out  1  to packet_sender.
- i_out_rdy  in  1  from packet_sender.
- o_pkt_start  out  1  one-cycle pulse starting a packet.
- o_pkt_len  out  16  byte length = {words[13:0],2'b00}; valid while o_pkt_start is high.
- o_busy  out  1  high in any state other than IDLE.
- o_drop_cnt  out  8  saturating count of requests lost because that source was already pending.

Behaviour:
- Reset values: all outputs 0; state IDLE; pending flags clear; round-robin pointer = frame.
- Requests:
  - A request pulse with length 0 is ignored.
  - A request arriving while its own source is still pending (not yet granted) is dropped: o_drop_cnt +1, saturating at 255; the stored length is unchanged.
  - A request for the source currently in XFER is accepted as a new pending request.
  - Both pulses in the same cycle are both latched.
- States:
  - IDLE: if any request is pending, pick a winner.
    - STAT_PRIO=1: status wins.
    - Otherwise round-robin: the source not granted last wins a tie; a lone request always wins.
    - Clear the winner's pending flag, load the word counter with its length, go to ANNOUNCE.
  - ANNOUNCE: exactly one cycle; o_pkt_start=1 with o_pkt_len; go to XFER.
  - XFER:
    - o_out_data/o_out_vld are combinationally muxed from the granted source, and its rdy = i_out_rdy.
    - The other source's rdy = 0.
    - Each cycle with o_out_vld & i_out_rdy decrements the counter.
    - On the beat that takes the counter 1->0, go to GAP (or IDLE if IFG_CYCLES=0).
  - GAP: o_out_vld=0; count IFG_CYCLES cycles, then go to IDLE.
- Latency: a request pulse sampled at edge N in IDLE gives o_pkt_start high in cycle N+2. The first data beat can transfer in cycle N+3.
- Source words presented outside XFER are back-pressured (rdy=0) and never lost.
- The granted source's vld low in XFER is a legal bubble; the counter holds.
- Pending requests accumulate during ANNOUNCE, XFER and GAP and are arbitrated at the next IDLE.
- Reset asserted mid-packet: the packet is abandoned immediately; pending flags are cleared and all outputs return to their reset values.

Optional Feature:
- Macro: TX_TIMEOUT_EN.
- With the macro:
  - In XFER, a stall counter counts cycles with no accepted beat while the source vld is low, and clears on any accepted beat.
  - When it reaches TIMEOUT_CYC, the arbiter stops listening to the source (source rdy=0) and emits the remaining words itself as 32'h0000_0000 with o_out_vld=1, so packet_sender receives the announced length.
  - Adds port o_timeout_cnt (out, 8), which increments saturating once per aborted packet.
- Without the macro: no watchdog; XFER waits indefinitely; port o_timeout_cnt is absent.

Test Plan:
- Frame only: i_frm_size=16, source always valid, i_out_rdy=1 -> o_pkt_start in cycle N+2 with o_pkt_len=64; 16 beats in consecutive cycles; o_frm_rdy low afterwards; o_busy low after 4 GAP cycles.
- Simultaneous requests, STAT_PRIO=0: frame 8 words plus status 3 words in the same cycle -> status granted first (pointer=frame at reset), o_pkt_len=12, then the frame packet with o_pkt_len=32; no interleaved words.
- Back-pressure: i_out_rdy toggles 1,0,1,0 over a 4-word status packet -> exactly 4 accepted beats, order preserved, counter holds on rdy=0.
- Drop: two i_frm_ready pulses while a status XFER is in progress -> o_drop_cnt=1; the frame packet is sent once with the first length.
- Zero length and reset: i_stat_len=0 -> no o_pkt_start. Then rst_n low after word 5 of a 16-word frame -> all outputs 0 within the reset cycle and no pending requests after release.
- TX_TIMEOUT_EN, TIMEOUT_CYC=32: frame vld drops after word 3 of 10 -> 32 stall cycles, then 7 zero words, o_timeout_cnt=1.

Source files
------------

// File: rtl/frame_tx_arbiter.sv
// ---------------------------------------------------------------------------
// frame_tx_arbiter
//
// Shares the single packet_sender input stream between the scope frame
// source and the short status/reply source. Each source raises a one-cycle
// request pulse carrying its packet length in 32-bit words. The request is
// latched as pending, and whole packets are granted one at a time. Words
// from different packets are never interleaved. Every packet is preceded
// by a one-cycle start pulse carrying its UDP byte length. The beat counter
// makes sure exactly the announced number of words is forwarded.
//
// Parameters:
//   IFG_CYCLES  - idle cycles forced between packets (0 = back-to-back)
//   TIMEOUT_CYC - stall watchdog limit in cycles (only with TX_TIMEOUT_EN)
//   STAT_PRIO   - 1: status always wins a tie, 0: round-robin
//
// Optional feature (macro TX_TIMEOUT_EN):
//   Stall watchdog in XFER. If the granted source holds vld low for
//   TIMEOUT_CYC cycles, the remaining words are padded with zeros and
//   o_timeout_cnt counts the aborted packets.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_frm_ready/size     frame request pulse + length (bits [15:14] ignored)
//   i_frm_data/vld/o_frm_rdy   frame stream
//   i_stat_req/len       status request pulse + length
//   i_stat_data/vld/o_stat_rdy status stream
//   o_out_data/vld/i_out_rdy   stream to packet_sender
//   o_pkt_start/o_pkt_len      packet start pulse with byte length
//   o_busy               arbiter not in IDLE
//   o_timeout_cnt        aborted-packet count (TX_TIMEOUT_EN only)
//   o_drop_cnt           saturating count of requests lost to a busy slot
// ---------------------------------------------------------------------------
module frame_tx_arbiter #(
    parameter int IFG_CYCLES  = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter bit STAT_PRIO   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_frm_ready,
    input  logic [15:0] i_frm_size,
    input  logic [31:0] i_frm_data,
    input  logic        i_frm_vld,
    output logic        o_frm_rdy,
    input  logic        i_stat_req,
    input  logic [7:0]  i_stat_len,
    input  logic [31:0] i_stat_data,
    input  logic        i_stat_vld,
    output logic        o_stat_rdy,
    output logic [31:0] o_out_data,
    output logic        o_out_vld,
    input  logic        i_out_rdy,
    output logic        o_pkt_start,
    output logic [15:0] o_pkt_len,
    output logic        o_busy,
`ifdef TX_TIMEOUT_EN
    output logic [7:0]  o_timeout_cnt,
`endif
    output logic [7:0]  o_drop_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ANNOUNCE,
        XFER,
        GAP
    } state_t;

    localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);

    state_t      state;
    state_t      state_next;

    logic        frm_pend;
    logic        stat_pend;
    logic [13:0] frm_len;
    logic [7:0]  stat_len;
    logic        last_frm;
    logic        sel_stat;
    logic [13:0] word_cnt;
    logic [15:0] gap_cnt;

    logic        grant;
    logic        grant_stat;
    logic        beat;
    logic        sel_vld;
    logic        frm_take;
    logic        stat_take;
    logic        frm_drop;
    logic        stat_drop;
    logic [8:0]  drop_sum;
    logic        flush_now;

    // The upper two frame size bits carry no meaning for this block.
    logic unused_size_bits;
    assign unused_size_bits = &{1'b0, i_frm_size[15:14]};

    assign o_busy  = (state != IDLE);
    assign sel_vld = sel_stat ? i_stat_vld : i_frm_vld;

    // A zero-length request never becomes pending.
    assign frm_take  = i_frm_ready && (i_frm_size[13:0] != 14'd0);
    assign stat_take = i_stat_req && (i_stat_len != 8'd0);

    // A slot being granted this very cycle is free to take a new request.
    assign frm_drop  = frm_take && frm_pend && !(grant && !grant_stat);
    assign stat_drop = stat_take && stat_pend && !(grant && grant_stat);
    assign drop_sum  = {1'b0, o_drop_cnt} + {8'd0, frm_drop} + {8'd0, stat_drop};

`ifdef TX_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [STALL_W-1:0] stall_cnt;
    logic               flush;

    assign flush_now = flush;

    // The watchdog only counts cycles where the granted source is idle.
    // Back-pressure from packet_sender is not a stall. After the limit,
    // the arbiter pads the remaining words itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= '0;
            flush         <= 1'b0;
            o_timeout_cnt <= 8'd0;
        end else if (state != XFER) begin
            stall_cnt <= '0;
            flush     <= 1'b0;
        end else if (!flush) begin
            if (beat) begin
                stall_cnt <= '0;
            end else if (!sel_vld) begin
                if (stall_cnt == STALL_W'(TIMEOUT_CYC - 1)) begin
                    flush <= 1'b1;
                    if (o_timeout_cnt != 8'hFF) begin
                        o_timeout_cnt <= o_timeout_cnt + 8'd1;
                    end
                end else begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign flush_now = 1'b0;

    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_stat  = 1'b0;
        beat        = 1'b0;
        o_out_data  = 32'd0;
        o_out_vld   = 1'b0;
        o_frm_rdy   = 1'b0;
        o_stat_rdy  = 1'b0;
        o_pkt_start = 1'b0;
        o_pkt_len   = 16'd0;

        case (state)
            IDLE: begin
                if (frm_pend || stat_pend) begin
                    grant = 1'b1;
                    // last_frm doubles as the round-robin pointer.
                    // Status wins a tie when frame was served last.
                    grant_stat = stat_pend && (!frm_pend || STAT_PRIO || last_frm);
                    state_next = ANNOUNCE;
                end
            end
            ANNOUNCE: begin
                o_pkt_start = 1'b1;
                o_pkt_len   = {word_cnt, 2'b00};
                state_next  = XFER;
            end
            XFER: begin
                if (flush_now) begin
                    o_out_vld = 1'b1;
                end else if (sel_stat) begin
                    o_out_data = i_stat_data;
                    o_out_vld  = i_stat_vld;
                    o_stat_rdy = i_out_rdy;
                end else begin
                    o_out_data = i_frm_data;
                    o_out_vld  = i_frm_vld;
                    o_frm_rdy  = i_out_rdy;
                end
                beat = o_out_vld && i_out_rdy;
                if (beat && (word_cnt == 14'd1)) begin
                    state_next = (IFG_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pending slots, grant bookkeeping, the word counter and the gap timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_pend   <= 1'b0;
            stat_pend  <= 1'b0;
            frm_len    <= 14'd0;
            stat_len   <= 8'd0;
            last_frm   <= 1'b1;
            sel_stat   <= 1'b0;
            word_cnt   <= 14'd0;
            gap_cnt    <= 16'd0;
            o_drop_cnt <= 8'd0;
        end else begin
            if (frm_take && !frm_drop) begin
                frm_pend <= 1'b1;
                frm_len  <= i_frm_size[13:0];
            end else if (grant && !grant_stat) begin
                frm_pend <= 1'b0;
            end

            if (stat_take && !stat_drop) begin
                stat_pend <= 1'b1;
                stat_len  <= i_stat_len;
            end else if (grant && grant_stat) begin
                stat_pend <= 1'b0;
            end

            o_drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];

            if (grant) begin
                sel_stat <= grant_stat;
                last_frm <= !grant_stat;
                word_cnt <= grant_stat ? {6'd0, stat_len} : frm_len;
            end else if (beat) begin
                word_cnt <= word_cnt - 14'd1;
            end

            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
        end
    end

endmodule

// File: tb/tb_frame_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_tx_arbiter
//
// Directed, self-checking bench for frame_tx_arbiter. Each source is a
// counting word generator. Expected output words and packet byte lengths
// are queued when a request is issued. A monitor on the falling edge pops
// and compares them whenever the DUT forwards a beat or announces a packet.
// Build with TX_TIMEOUT_EN defined to also exercise the stall watchdog.
// ---------------------------------------------------------------------------
module tb_frame_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_frm_ready;
    logic [15:0] i_frm_size;
    logic [31:0] i_frm_data;
    logic        i_frm_vld;
    logic        o_frm_rdy;
    logic        i_stat_req;
    logic [7:0]  i_stat_len;
    logic [31:0] i_stat_data;
    logic        i_stat_vld;
    logic        o_stat_rdy;
    logic [31:0] o_out_data;
    logic        o_out_vld;
    logic        i_out_rdy;
    logic        o_pkt_start;
    logic [15:0] o_pkt_len;
    logic        o_busy;
    logic [7:0]  o_drop_cnt;
`ifdef TX_TIMEOUT_EN
    logic [7:0]  o_timeout_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_words[$];
    logic [15:0] exp_lens[$];

    int frm_idx   = 0;
    int stat_idx  = 0;
    int frm_next  = 0;
    int stat_next = 0;

    frame_tx_arbiter #(
        .IFG_CYCLES  (4),
        .TIMEOUT_CYC (32),
        .STAT_PRIO   (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frm_ready  (i_frm_ready),
        .i_frm_size   (i_frm_size),
        .i_frm_data   (i_frm_data),
        .i_frm_vld    (i_frm_vld),
        .o_frm_rdy    (o_frm_rdy),
        .i_stat_req   (i_stat_req),
        .i_stat_len   (i_stat_len),
        .i_stat_data  (i_stat_data),
        .i_stat_vld   (i_stat_vld),
        .o_stat_rdy   (o_stat_rdy),
        .o_out_data   (o_out_data),
        .o_out_vld    (o_out_vld),
        .i_out_rdy    (i_out_rdy),
        .o_pkt_start  (o_pkt_start),
        .o_pkt_len    (o_pkt_len),
        .o_busy       (o_busy),
`ifdef TX_TIMEOUT_EN
        .o_timeout_cnt(o_timeout_cnt),
`endif
        .o_drop_cnt   (o_drop_cnt)
    );

    always #5 clk = ~clk;

    // Counting sources: each word accepted by the DUT advances its stream.
    assign i_frm_data  = 32'hF000_0000 + 32'(frm_idx);
    assign i_stat_data = 32'h5A00_0000 + 32'(stat_idx);

    always @(posedge clk) begin
        if (i_frm_vld && o_frm_rdy) frm_idx <= frm_idx + 1;
        if (i_stat_vld && o_stat_rdy) stat_idx <= stat_idx + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard monitor: beats and start pulses are judged just before the
    // edge that accepts them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_out_vld && i_out_rdy) begin
                checkOutput("beat_expected", 32'(exp_words.size() != 0), 32'd1);
                if (exp_words.size() != 0) checkOutput("beat_data", o_out_data, exp_words.pop_front());
            end
            if (o_pkt_start) begin
                checkOutput("start_expected", 32'(exp_lens.size() != 0), 32'd1);
                if (exp_lens.size() != 0) checkOutput("pkt_len", 32'(o_pkt_len), 32'(exp_lens.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic frm_req, input logic [15:0] frm_size,
                                 input logic stat_req, input logic [7:0] stat_len);
        i_frm_ready = frm_req;
        i_frm_size  = frm_size;
        i_stat_req  = stat_req;
        i_stat_len  = stat_len;
        tick();
        i_frm_ready = 1'b0;
        i_stat_req  = 1'b0;
    endtask

    task automatic pushFrame(input int n);
        for (int k = 0; k < n; k++) begin
            exp_words.push_back(32'hF000_0000 + 32'(frm_next));
            frm_next++;
        end
    endtask

    task automatic pushStat(input int n);
        for (int k = 0; k < n; k++) begin
            exp_words.push_back(32'h5A00_0000 + 32'(stat_next));
            stat_next++;
        end
    endtask

    task automatic pushZeros(input int n);
        for (int k = 0; k < n; k++) exp_words.push_back(32'd0);
    endtask

    task automatic pushLen(input int words);
        exp_lens.push_back(16'(words * 4));
    endtask

    task automatic waitIdle(input int max_cycles);
        int n = 0;
        while (n < max_cycles && !(exp_words.size() == 0 && exp_lens.size() == 0 && !o_busy)) begin
            tick();
            n++;
        end
        checkOutput("drain", 32'(n < max_cycles), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beats;
        int base;
        int stall;

        rst_n       = 1'b0;
        i_frm_ready = 1'b0;
        i_frm_size  = 16'd0;
        i_frm_vld   = 1'b1;
        i_stat_req  = 1'b0;
        i_stat_len  = 8'd0;
        i_stat_vld  = 1'b1;
        i_out_rdy   = 1'b1;
        #1;
        repeat (3) tick();

        // Reset state.
        checkOutput("rst_out_vld", 32'(o_out_vld), 32'd0);
        checkOutput("rst_out_data", o_out_data, 32'd0);
        checkOutput("rst_pkt_start", 32'(o_pkt_start), 32'd0);
        checkOutput("rst_pkt_len", 32'(o_pkt_len), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_frm_rdy", 32'(o_frm_rdy), 32'd0);
        checkOutput("rst_stat_rdy", 32'(o_stat_rdy), 32'd0);
        checkOutput("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Frame only: latency, 16 back-to-back beats, then 4 gap cycles.
        pushFrame(16);
        pushLen(16);
        applyStimulus(1'b1, 16'd16, 1'b0, 8'd0);
        checkOutput("t1_no_start_early", 32'(o_pkt_start), 32'd0);
        tick();
        checkOutput("t1_start", 32'(o_pkt_start), 32'd1);
        checkOutput("t1_len", 32'(o_pkt_len), 32'd64);
        tick();
        beats = 0;
        for (int i = 0; i < 16; i++) begin
            if (o_out_vld && i_out_rdy) beats++;
            tick();
        end
        checkOutput("t1_beats", 32'(beats), 32'd16);
        checkOutput("t1_frm_rdy_after", 32'(o_frm_rdy), 32'd0);
        checkOutput("t1_busy_in_gap", 32'(o_busy), 32'd1);
        repeat (3) tick();
        checkOutput("t1_busy_gap_end", 32'(o_busy), 32'd1);
        tick();
        checkOutput("t1_idle", 32'(o_busy), 32'd0);

        // Simultaneous requests: status wins the tie, then frame.
        pushStat(3);
        pushLen(3);
        pushFrame(8);
        pushLen(8);
        applyStimulus(1'b1, 16'd8, 1'b1, 8'd3);
        waitIdle(200);

        // Back-pressure on a 4-word status packet.
        pushStat(4);
        pushLen(4);
        applyStimulus(1'b0, 16'd0, 1'b1, 8'd4);
        tick();
        tick();
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            i_out_rdy = (i % 2 == 0);
            if (o_out_vld && i_out_rdy) beats++;
            tick();
        end
        i_out_rdy = 1'b1;
        checkOutput("t3_beats", 32'(beats), 32'd4);
        checkOutput("t3_vld_in_gap", 32'(o_out_vld), 32'd0);
        checkOutput("t3_busy_in_gap", 32'(o_busy), 32'd1);
        waitIdle(100);

        // Round-robin: status was served last, so frame wins this tie.
        pushFrame(2);
        pushLen(2);
        pushStat(2);
        pushLen(2);
        applyStimulus(1'b1, 16'd2, 1'b1, 8'd2);
        waitIdle(200);

        // Drop: second frame request during a status transfer is lost.
        pushStat(6);
        pushLen(6);
        pushFrame(5);
        pushLen(5);
        applyStimulus(1'b0, 16'd0, 1'b1, 8'd6);
        tick();
        tick();
        applyStimulus(1'b1, 16'd5, 1'b0, 8'd0);
        applyStimulus(1'b1, 16'd9, 1'b0, 8'd0);
        checkOutput("t5_drop_cnt", 32'(o_drop_cnt), 32'd1);
        waitIdle(200);
        repeat (6) tick();
        checkOutput("t5_no_resend", 32'(o_busy), 32'd0);

        // Zero-length request is ignored and is not a drop.
        applyStimulus(1'b0, 16'd0, 1'b1, 8'd0);
        repeat (4) tick();
        checkOutput("t6_zero_busy", 32'(o_busy), 32'd0);
        checkOutput("t6_zero_drop", 32'(o_drop_cnt), 32'd1);

        // Reset after word 5 of a 16-word frame, with a status request pending.
        base = frm_next;
        pushFrame(16);
        pushLen(16);
        applyStimulus(1'b1, 16'd16, 1'b0, 8'd0);
        beats = 0;
        for (int i = 0; i < 40; i++) begin
            i_stat_req = (i == 2);
            i_stat_len = 8'd2;
            if (o_out_vld && i_out_rdy) beats++;
            tick();
            if (beats == 5) break;
        end
        i_stat_req = 1'b0;
        checkOutput("t7_beats_before_rst", 32'(beats), 32'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("t7_rst_out_vld", 32'(o_out_vld), 32'd0);
        checkOutput("t7_rst_out_data", o_out_data, 32'd0);
        checkOutput("t7_rst_busy", 32'(o_busy), 32'd0);
        checkOutput("t7_rst_frm_rdy", 32'(o_frm_rdy), 32'd0);
        checkOutput("t7_rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
        exp_words.delete();
        exp_lens.delete();
        frm_next = base + 5;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        checkOutput("t7_no_pending", 32'(o_busy), 32'd0);
        checkOutput("t7_stat_rdy", 32'(o_stat_rdy), 32'd0);

`ifdef TX_TIMEOUT_EN
        // Frame source stalls after word 3 of 10: 32 stall cycles, then 7 zero words.
        pushFrame(3);
        pushZeros(7);
        pushLen(10);
        applyStimulus(1'b1, 16'd10, 1'b0, 8'd0);
        beats = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_out_vld && i_out_rdy) beats++;
            tick();
            if (beats == 3) break;
        end
        i_frm_vld = 1'b0;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            if (o_out_vld) break;
            stall++;
            tick();
        end
        checkOutput("t8_stall_cycles", 32'(stall), 32'd32);
        waitIdle(100);
        checkOutput("t8_timeout_cnt", 32'(o_timeout_cnt), 32'd1);
        i_frm_vld = 1'b1;
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
